// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result streaming bundle for addsub_pipe.
// The slave modport is the arithmetic unit. The master modport is its driver.
interface addsub_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf, zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor.
// The carry chain is cut into CHUNK-bit slices, and each pipeline stage resolves
// one slice, so the latency is WIDTH/CHUNK cycles.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow. The default
// build wraps the result modulo 2^WIDTH.
module addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic          clk,
    input logic          rst_n,
    addsub_pipe_if.slave bus
);
    localparam int STAGES = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int LAST   = STAGES - 1;

    if (CHUNK < 1) begin : g_bad_chunk
        $error("addsub_pipe: CHUNK must be >= 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("addsub_pipe: WIDTH must be a multiple of CHUNK");
    end

    // Stage k holds everything needed to resolve slice k+1: the carry out of
    // slice k, the result bits produced so far, and the operands. B is stored
    // already inverted for a subtract.
    logic             r_vld [STAGES];
    logic             r_cy  [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_res [STAGES];

    logic             w_vin    [STAGES];
    logic             w_cin    [STAGES];
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_res_in [STAGES];
    logic [WIDTH-1:0] w_res_nx [STAGES];
    logic [CHUNK:0]   w_sum    [STAGES];

    logic             r_result;
    logic [WIDTH-1:0] r_result_q;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_adv;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_final;

    // A stall freezes the whole pipe, bubbles included.
    assign w_adv        = !r_vld[LAST] || bus.out_ready;
    assign bus.in_ready = w_adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        if (k == 0) begin : g_head
            assign w_vin[k]    = bus.in_valid;
            assign w_cin[k]    = bus.sub;
            assign w_a_in[k]   = bus.a;
            assign w_b_in[k]   = bus.sub ? ~bus.b : bus.b;
            assign w_res_in[k] = '0;
        end else begin : g_body
            assign w_vin[k]    = r_vld[k-1];
            assign w_cin[k]    = r_cy[k-1];
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_res_in[k] = r_res[k-1];
        end
        assign w_sum[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                        + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                        + {{CHUNK{1'b0}}, w_cin[k]};
        // The upper result bits are still zero here, so OR-ing in the new slice is enough.
        assign w_res_nx[k] = w_res_in[k] | (WIDTH'(w_sum[k][CHUNK-1:0]) << (k * CHUNK));
    end

    // The carry into the MSB is recovered from the MSB sum bit and its two input bits.
    assign w_cout = w_sum[LAST][CHUNK];
    assign w_cmsb = w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1] ^ w_sum[LAST][CHUNK-1];
    assign w_ovf  = w_cmsb ^ w_cout;

`ifdef ADDSUB_SAT_EN
    // Clamp toward the sign of A. Neither an add nor a subtract can overflow
    // unless the true result has the same sign as A.
    assign w_final = !w_ovf ? w_res_nx[LAST]
                   : (w_a_in[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign w_final = w_res_nx[LAST];
`endif

    // Shift every stage forward together whenever the output side can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_cy[k]  <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_vin[k];
                r_cy[k]  <= w_sum[k][CHUNK];
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_res[k] <= w_res_nx[k];
            end
        end
    end

    // Output result and flags. They update only when a valid beat lands, so
    // bubbles leave the last values in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_adv && w_vin[LAST]) begin
            r_result_q <= w_final;
            r_cout     <= w_cout;
            r_ovf      <= w_ovf;
            r_zero     <= (w_final == '0);
        end
    end

    assign r_result      = r_vld[LAST];
    assign bus.out_valid = r_result;
    assign bus.result    = r_result_q;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;
endmodule
